// File: rtl/axil_reg_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
// Holds the AXI response codes and the helper that turns a byte address
// into a 32-bit word offset. No ports; imported by axil_reg_bank.
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word offset of a byte address; the two byte-lane bits are dropped.
    function automatic int unsigned reg_offset(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/axil_reset_pulse.sv
// Retriggerable fixed-length pulse generator.
// A trigger loads a down-counter with LEN; the pulse is high while the
// count is non-zero, so it starts on the cycle after the trigger and lasts
// exactly LEN cycles. A retrigger reloads the counter and restarts the pulse.
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset (drops the pulse immediately)
//   trig  - single-cycle trigger
//   pulse - active-high output pulse
module axil_reset_pulse #(
    parameter int LEN = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic trig,
    output logic pulse
);

    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= CW'(LEN);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank shared between the PS (AXI) and the PL.
// Map: register i at byte 4*i, STATUS at 4*C_NUM_REGS (write-1-to-clear,
// bit i set by a PL write to register i), IRQ_EN at 4*(C_NUM_REGS+1).
// Read-only registers are loaded by the PL; pulse registers self-clear one
// cycle after an AXI write. Bit 0 written to C_RST_REG fires aux_pl_res.
// Ports:
//   s00_axi_*   - AXI4-Lite slave (AW and W accepted together, no wstrb)
//   pl_wdata    - flattened PL write data, slice i -> register i
//   pl_wr_en    - per-register PL write strobe (read-only registers only)
//   regs_out    - flattened current register values
//   reg_wr_busy - AXI write in flight (handshake through B handshake)
//   irq         - registered |(STATUS & IRQ_EN)
//   aux_pl_res  - active-high PL reset pulse
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int                    C_S00_AXI_DATA_WIDTH = 32,
    parameter int                    C_S00_AXI_ADDR_WIDTH = 6,
    parameter int                    C_NUM_REGS           = 8,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK            = 8'b1000_0011,
    parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK         = 8'b0000_0000,
    parameter int                    C_RST_REG            = 5,
    parameter int                    C_RST_PULSE_LEN      = 16
) (
    input  logic                                       s00_axi_aclk,
    input  logic                                       s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
    input  logic                                       s00_axi_awvalid,
    output logic                                       s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
    input  logic                                       s00_axi_wvalid,
    output logic                                       s00_axi_wready,
    output logic [1:0]                                 s00_axi_bresp,
    output logic                                       s00_axi_bvalid,
    input  logic                                       s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
    input  logic                                       s00_axi_arvalid,
    output logic                                       s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
    output logic [1:0]                                 s00_axi_rresp,
    output logic                                       s00_axi_rvalid,
    input  logic                                       s00_axi_rready,
    input  logic [C_NUM_REGS*C_S00_AXI_DATA_WIDTH-1:0] pl_wdata,
    input  logic [C_NUM_REGS-1:0]                      pl_wr_en,
    output logic [C_NUM_REGS*C_S00_AXI_DATA_WIDTH-1:0] regs_out,
    output logic                                       reg_wr_busy,
    output logic                                       irq,
    output logic                                       aux_pl_res
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int NR = C_NUM_REGS;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] status_q, irq_en_q;
    logic          aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q, irq_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;

    int unsigned   wr_idx, rd_idx;
    logic          wr_hs, rd_hs;
    logic [NR-1:0] wr_reg_sel;
    logic          wr_status, wr_irq_en, wr_err;
    logic [DW-1:0] rd_val;
    logic          rd_err;
    logic [DW-1:0] pl_set;
    logic          rst_trig;

    assign wr_hs  = aw_rdy_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_hs  = ar_rdy_q & s00_axi_arvalid;
    assign wr_idx = reg_offset(32'(s00_axi_awaddr));
    assign rd_idx = reg_offset(32'(s00_axi_araddr));
    assign pl_set = DW'(pl_wr_en & C_RO_MASK);

    // Write decode: read-only registers and unmapped offsets are rejected.
    always_comb begin
        wr_reg_sel = '0;
        wr_status  = 1'b0;
        wr_irq_en  = 1'b0;
        wr_err     = 1'b1;
        for (int unsigned i = 0; i < NR; i++) begin
            if (wr_idx == i && !C_RO_MASK[i]) begin
                wr_reg_sel[i] = 1'b1;
                wr_err        = 1'b0;
            end
        end
        if (wr_idx == unsigned'(NR)) begin
            wr_status = 1'b1;
            wr_err    = 1'b0;
        end
        if (wr_idx == unsigned'(NR + 1)) begin
            wr_irq_en = 1'b1;
            wr_err    = 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        rd_err = 1'b1;
        for (int unsigned i = 0; i < NR; i++) begin
            if (rd_idx == i) begin
                rd_val = regs[i];
                rd_err = 1'b0;
            end
        end
        if (rd_idx == unsigned'(NR)) begin
            rd_val = status_q;
            rd_err = 1'b0;
        end
        if (rd_idx == unsigned'(NR + 1)) begin
            rd_val = irq_en_q;
            rd_err = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int unsigned i = 0; i < NR; i++) regs[i] <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (C_RO_MASK[i]) begin
                    if (pl_wr_en[i]) regs[i] <= pl_wdata[i*DW +: DW];
                end else if (wr_hs && wr_reg_sel[i]) begin
                    regs[i] <= s00_axi_wdata;
                end else if (C_PULSE_MASK[i]) begin
                    regs[i] <= '0;
                end
            end
            // Clear applied first so a same-cycle PL set wins.
            status_q <= (status_q & ~((wr_hs && wr_status) ? s00_axi_wdata : '0)) | pl_set;
            if (wr_hs && wr_irq_en) irq_en_q <= s00_axi_wdata;
            irq_q <= |(status_q & irq_en_q);
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            // The !aw_rdy_q / !ar_rdy_q terms keep the ready strobes to one cycle.
            aw_rdy_q <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~aw_rdy_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            ar_rdy_q <= s00_axi_arvalid & ~rvalid_q & ~ar_rdy_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign rst_trig = wr_hs & wr_reg_sel[C_RST_REG] & s00_axi_wdata[0];

    axil_reset_pulse #(
        .LEN (C_RST_PULSE_LEN)
    ) u_reset_pulse (
        .clk   (s00_axi_aclk),
        .rstn  (s00_axi_aresetn),
        .trig  (rst_trig),
        .pulse (aux_pl_res)
    );

    for (genvar g = 0; g < NR; g++) begin : g_regs_out
        assign regs_out[g*DW +: DW] = regs[g];
    end

    // PL data/strobes of AXI-written registers are intentionally ignored.
    logic unused_pl;
    assign unused_pl = ^{pl_wdata, pl_wr_en};

    assign s00_axi_awready = aw_rdy_q;
    assign s00_axi_wready  = aw_rdy_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = ar_rdy_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign reg_wr_busy     = aw_rdy_q | bvalid_q;
    assign irq             = irq_q;

endmodule
